// File: rtl/ppi_bus_master_if.sv
// Request/response and PPI bus signals of the PPI bus master.
// The master modport is the initiator side; slave is the system plus PPI side.
interface ppi_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       CS_bar;
    logic       RD_bar;
    logic       WR_bar;
    logic       A0;
    logic       A1;
    logic [7:0] D_out;
    logic       D_oe;
    logic [7:0] D_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, D_in,
        output req_ready, rsp_valid, rsp_rdata,
        output CS_bar, RD_bar, WR_bar, A0, A1, D_out, D_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, D_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  CS_bar, RD_bar, WR_bar, A0, A1, D_out, D_oe
    );
endinterface

// File: rtl/ppi_bus_master.sv
// CPU-side initiator for an 8255-style PPI: turns valid/ready requests into
// SETUP/STROBE/HOLD bus cycles with fully registered outputs.
module ppi_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RESET_bar,
    ppi_bus_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    localparam logic [3:0] SetupLoad  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLoad   = 4'(HOLD_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       cs_bar_q, cs_bar_d;
    logic       rd_bar_q, rd_bar_d;
    logic       wr_bar_q, wr_bar_d;
    logic [1:0] bus_addr_q, bus_addr_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ready_q, ready_d;

    logic accept;

    // ready_q is high exactly in IDLE, so it doubles as the acceptance qualifier
    assign accept = bus.req_valid && ready_q;

    always_ff @(posedge CLK or negedge RESET_bar) begin
        if (!RESET_bar) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered bus pins
    // line up with the state they belong to.
    always_comb begin
        cs_bar_d    = 1'b1;
        rd_bar_d    = 1'b1;
        wr_bar_d    = 1'b1;
        doe_d       = 1'b0;
        bus_addr_d  = bus_addr_q;
        dout_d      = dout_q;
        rdata_d     = rdata_q;
        ready_d     = (state_d == StIdle);
        rsp_valid_d = (state_q == StHold) && (state_d == StIdle);

        unique case (state_d)
            StIdle: begin
                ready_d = 1'b1;
            end
            StSetup, StHold: begin
                cs_bar_d   = 1'b0;
                bus_addr_d = addr_d;
                doe_d      = write_d;
                if (write_d) begin
                    dout_d = wdata_d;
                end
            end
            StStrobe: begin
                cs_bar_d   = 1'b0;
                bus_addr_d = addr_d;
                doe_d      = write_d;
                rd_bar_d   = write_d;
                wr_bar_d   = !write_d;
                if (write_d) begin
                    dout_d = wdata_d;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase

        // Capture on the edge that ends the last strobe cycle, as RD_bar rises
        if ((state_q == StStrobe) && (state_d == StHold) && !write_q) begin
            rdata_d = bus.D_in;
        end
    end

    always_ff @(posedge CLK or negedge RESET_bar) begin
        if (!RESET_bar) begin
            cs_bar_q    <= 1'b1;
            rd_bar_q    <= 1'b1;
            wr_bar_q    <= 1'b1;
            bus_addr_q  <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
        end else begin
            cs_bar_q    <= cs_bar_d;
            rd_bar_q    <= rd_bar_d;
            wr_bar_q    <= wr_bar_d;
            bus_addr_q  <= bus_addr_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.CS_bar    = cs_bar_q;
    assign bus.RD_bar    = rd_bar_q;
    assign bus.WR_bar    = wr_bar_q;
    assign bus.A0        = bus_addr_q[0];
    assign bus.A1        = bus_addr_q[1];
    assign bus.D_out     = dout_q;
    assign bus.D_oe      = doe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.req_ready = ready_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: directed bus-timing checks plus random traffic
// against a register-file reference model, with a response scoreboard.
module tb_ppi_bus_master;

    localparam int SetupCyc  = 1;
    localparam int StrobeCyc = 2;
    localparam int HoldCyc   = 1;
    localparam int BusCyc    = SetupCyc + StrobeCyc + HoldCyc;

    logic CLK;
    logic RESET_bar;

    ppi_bus_master_if bus ();

    ppi_bus_master #(
        .SETUP_CYC (SetupCyc),
        .STROBE_CYC(StrobeCyc),
        .HOLD_CYC  (HoldCyc)
    ) dut (
        .CLK      (CLK),
        .RESET_bar(RESET_bar),
        .bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       write;
        logic [1:0] addr;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem[4];
    logic [7:0] last_rdata;
    int         n_checks;
    int         n_pass;

    // PPI-side model: registers written on the WR_bar rising edge, read data
    // valid only while RD_bar is low (a distinct pattern otherwise).
    logic [7:0] ppi_mem[4];
    logic       wr_seen;
    logic [1:0] wr_a;
    logic [7:0] wr_v;
    logic [7:0] rd_val;

    assign rd_val   = ppi_mem[{bus.A1, bus.A0}];
    assign bus.D_in = (!bus.CS_bar && !bus.RD_bar) ? rd_val : (rd_val ^ 8'hA5);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (!RESET_bar) begin
            wr_seen = 1'b0;
        end else if (!bus.CS_bar && !bus.WR_bar) begin
            wr_seen = 1'b1;
            wr_a    = {bus.A1, bus.A0};
            wr_v    = bus.D_out;
        end else if (wr_seen && !bus.CS_bar && bus.WR_bar) begin
            ppi_mem[wr_a] = wr_v;
            wr_seen       = 1'b0;
        end else if (bus.CS_bar) begin
            wr_seen = 1'b0;
        end
    end

    // Scoreboard: every response pops the oldest expected transaction.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET_bar && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk(e.write ? "rsp_rdata_after_write" : "rsp_rdata_read", bus.rsp_rdata,
                    e.rdata);
            end
        end
    end

    // Bus protocol monitor: invariants plus strobe and chip-select lengths.
    int cs_run, rd_run, wr_run;
    always @(negedge CLK) begin
        if (!RESET_bar) begin
            cs_run = 0;
            rd_run = 0;
            wr_run = 0;
        end else begin
            chk("strobe_invariants",
                {31'd0, !((!bus.RD_bar && !bus.WR_bar) ||
                          (bus.CS_bar && (!bus.RD_bar || !bus.WR_bar)) ||
                          (bus.D_oe && !bus.RD_bar))}, 32'd1);
            if (!bus.CS_bar) cs_run++;
            else if (cs_run != 0) begin
                chk("cs_low_length", 32'(cs_run), 32'(BusCyc));
                cs_run = 0;
            end
            if (!bus.RD_bar) rd_run++;
            else if (rd_run != 0) begin
                chk("rd_low_length", 32'(rd_run), 32'(StrobeCyc));
                rd_run = 0;
            end
            if (!bus.WR_bar) wr_run++;
            else if (wr_run != 0) begin
                chk("wr_low_length", 32'(wr_run), 32'(StrobeCyc));
                wr_run = 0;
            end
        end
    end

    task automatic push_exp(input logic w, input logic [1:0] a, input logic [7:0] d);
        exp_t e;
        e.write = w;
        e.addr  = a;
        if (w) begin
            ref_mem[a] = d;
        end else begin
            last_rdata = ref_mem[a];
        end
        e.rdata = last_rdata;
        exp_q.push_back(e);
    endtask

    // Call just after a negedge or just after a posedge; returns 1 time unit
    // after the acceptance edge.
    task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d);
        int budget;
        budget        = 40;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (!bus.req_ready) begin
            chk("req_accept", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            push_exp(w, a, d);
            @(posedge CLK);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        int rsp_cnt;
        int k;
        logic [7:0] d;

        n_checks      = 0;
        n_pass        = 0;
        last_rdata    = 8'h00;
        RESET_bar     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 2'd0;
        bus.req_wdata = 8'h00;

        // Reset
        repeat (3) @(negedge CLK);
        RESET_bar = 1'b1;
        @(negedge CLK);
        chk("rst_cs_bar", bus.CS_bar, 1);
        chk("rst_rd_bar", bus.RD_bar, 1);
        chk("rst_wr_bar", bus.WR_bar, 1);
        chk("rst_addr", {bus.A1, bus.A0}, 0);
        chk("rst_d_out", bus.D_out, 0);
        chk("rst_d_oe", bus.D_oe, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_req_ready", bus.req_ready, 1);

        // Give every PPI register a known value
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 2'(i), 8'($urandom));
            @(negedge CLK);
        end
        repeat (6) @(negedge CLK);

        // Control-word write: cycle 1 is the first cycle with CS_bar low
        do_req(1'b1, 2'd3, 8'h80);
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            chk($sformatf("cw_cs_bar_c%0d", c), bus.CS_bar, (c <= 4) ? 0 : 1);
            chk($sformatf("cw_wr_bar_c%0d", c), bus.WR_bar, (c == 2 || c == 3) ? 0 : 1);
            chk($sformatf("cw_rsp_valid_c%0d", c), bus.rsp_valid, (c == 5) ? 1 : 0);
            chk($sformatf("cw_d_oe_c%0d", c), bus.D_oe, (c <= 4) ? 1 : 0);
            if (c <= 4) begin
                chk($sformatf("cw_addr_c%0d", c), {bus.A1, bus.A0}, 3);
                chk($sformatf("cw_d_out_c%0d", c), bus.D_out, 8'h80);
            end
        end

        // Read port B: PPI returns 0x5A while RD_bar is low, 0xFF afterwards
        do_req(1'b1, 2'd1, 8'h5A);
        repeat (6) @(negedge CLK);
        do_req(1'b0, 2'd1, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            chk($sformatf("rd_cs_bar_c%0d", c), bus.CS_bar, (c <= 4) ? 0 : 1);
            chk($sformatf("rd_rd_bar_c%0d", c), bus.RD_bar, (c == 2 || c == 3) ? 0 : 1);
            chk($sformatf("rd_d_oe_c%0d", c), bus.D_oe, 0);
            if (c == 4) chk("rd_d_in_after_strobe", bus.D_in, 8'hFF);
            if (c >= 5) chk($sformatf("rd_rdata_c%0d", c), bus.rsp_rdata, 8'h5A);
            chk($sformatf("rd_rsp_valid_c%0d", c), bus.rsp_valid, (c == 5) ? 1 : 0);
        end

        // Back-to-back: write 0x11 to port A, then read port C with valid held
        do_req(1'b1, 2'd0, 8'h11);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 2'd2;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!bus.req_ready && k < 20);
        chk("b2b_accept_cycle", 32'(k), 32'(BusCyc + 1));
        chk("b2b_rsp_valid_at_accept", bus.rsp_valid, 1);
        chk("b2b_cs_gap", bus.CS_bar, 1);
        push_exp(1'b0, 2'd2, 8'h00);
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_second_cs_bar", bus.CS_bar, 0);
        chk("b2b_second_addr", {bus.A1, bus.A0}, 2);
        repeat (6) @(negedge CLK);

        // Busy ignore: a request pulsed during STROBE has no effect
        do_req(1'b1, 2'd1, 8'h77);
        @(negedge CLK);
        @(negedge CLK);
        chk("busy_wr_bar", bus.WR_bar, 0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 2'd2;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        chk("busy_req_ready", bus.req_ready, 0);
        chk("busy_addr_c3", {bus.A1, bus.A0}, 1);
        rsp_cnt = 0;
        for (int c = 4; c <= 10; c++) begin
            @(negedge CLK);
            if (c == 4) chk("busy_addr_c4", {bus.A1, bus.A0}, 1);
            if (bus.rsp_valid) rsp_cnt++;
        end
        chk("busy_rsp_count", 32'(rsp_cnt), 32'd1);

        // Reset during a write strobe
        d = ref_mem[0];
        do_req(1'b1, 2'd0, d);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_wr_bar_before", bus.WR_bar, 0);
        #2;
        RESET_bar = 1'b0;
        #1;
        chk("abort_cs_bar", bus.CS_bar, 1);
        chk("abort_wr_bar", bus.WR_bar, 1);
        chk("abort_d_oe", bus.D_oe, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        void'(exp_q.pop_back());
        last_rdata = 8'h00;
        repeat (2) @(negedge CLK);
        RESET_bar = 1'b1;
        rsp_cnt = 0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.rsp_valid) rsp_cnt++;
        end
        chk("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        chk("abort_rdata_reset", bus.rsp_rdata, 0);
        do_req(1'b0, 2'd0, 8'h00);
        repeat (6) @(negedge CLK);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
